// File: rtl/enc_pkg.sv
// Shared constants and helpers for the enc_pri_rr request encoder.
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_N      = 64;

  // Index width that never collapses to zero bits for tiny N.
  function automatic int clog2Safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multiHot(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/enc_pri_rr_pick.sv
// Combinational picker: first set request bit scanning upward from start, wrapping at N.
import enc_pkg::*;

module rr_pick #(
  parameter  int N = 8,
  localparam int W = clog2Safe(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         hit,
  output logic [W-1:0] idx
);

  int pos;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!hit && req[pos[W-1:0]]) begin
        hit = 1'b1;
        idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/enc_pri_rr.sv
// N-input fixed-priority / round-robin request encoder with a registered valid/ready output.
// Optional saturating multi-hot capture counter enabled by defining ENC_MULTI_CNT_EN.
import enc_pkg::*;

module enc_pri_rr #(
  parameter  int N = 8,
  localparam int W = clog2Safe(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
`ifdef ENC_MULTI_CNT_EN
  ,
  input  logic         cnt_clr,
  output logic [15:0]  multi_cnt
`endif
);

  logic         valid_q, valid_d;
  logic         multi_q, multi_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         slotFree, capture, pickHit, multiNow;
  logic [W-1:0] startIdx, pickIdx, ptrNext;

  // Fixed priority is simply a round-robin scan that always starts at index 0.
  assign startIdx = (mode == MODE_RR) ? ptr_q : '0;

  rr_pick #(.N(N)) uPick (
    .req   (req),
    .start (startIdx),
    .hit   (pickHit),
    .idx   (pickIdx)
  );

  assign slotFree = !valid_q || out_ready;
  assign capture  = en && pickHit && slotFree;
  assign multiNow = multiHot(MAX_N'(req));
  assign ptrNext  = (pickIdx == W'(N - 1)) ? '0 : pickIdx + W'(1);

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (capture) begin
      valid_d = 1'b1;
      idx_d   = pickIdx;
      multi_d = multiNow;
      if (mode == MODE_RR) ptr_d = ptrNext;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;

`ifdef ENC_MULTI_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (capture && multiNow && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign multi_cnt = cnt_q;
`endif

endmodule

// File: doc/enc_pri_rr.md
Name: enc_pri_rr

Overview:
- Parametrised N-input request encoder with a registered output and a valid/ready output stage.
- Selectable arbitration mode: fixed priority (lowest index wins) or round-robin (rotating pointer).
- Flags multi-hot inputs instead of producing an undefined code.
- Front end for interrupt/request aggregation; feeds one index per cycle to a downstream consumer.

Parameters:
- N, 8, number of request inputs (2..64).
- W, $clog2(N), index width; localparam derived from N, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when low, no new capture occurs.
- mode  input  1  0 = fixed priority, 1 = round-robin.
- req  input  N  request vector; bit i requests index i.
- out_ready  input  1  downstream accepts out_idx this cycle.
- out_valid  output  1  out_idx/out_multi hold a valid result.
- out_idx  output  W  encoded winning index.
- out_multi  output  1  more than one req bit was set at capture.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_idx=0, out_multi=0, rr pointer ptr=0. All are cleared immediately, including mid-transfer; a held result is discarded.
- Slot free: slot_free = !out_valid || out_ready.
- Capture condition: en && (|req) && slot_free. On capture, at the next clock edge:
  - out_valid=1.
  - out_idx=winner.
  - out_multi=(popcount(req)>1).
- Pop without capture: out_valid && out_ready && no capture gives out_valid=0 next cycle. out_idx and out_multi hold their last values.
- Simultaneous pop and capture: the register is overwritten with the new result. out_valid stays 1, no bubble, giving one result per cycle of throughput.
- Backpressure: out_valid && !out_ready means the output is frozen. req changes are ignored, and there is no capture and no ptr update.
- Latency: exactly 1 cycle from the capturing edge to out_valid.
- Empty input: req=0 or en=0 means no capture. This is not an error, and out_idx never shows high-Z or X.
- Winner, mode 0: lowest set index.
- Winner, mode 1: first set index scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wrap-around).
- ptr update: only on capture with mode=1, ptr = (winner+1) mod N. When winner=N-1, ptr wraps to 0.
  - In mode 0, ptr holds its value.
  - Switching mode does not reset ptr.
- Single-hot req: both modes give the same index.
- mode sampling: mode is sampled only at capture.

Optional Feature:
- Macro: ENC_MULTI_CNT_EN.
- Defined:
  - Extra output multi_cnt, 16 bits.
  - It increments on every capture with out_multi-condition true.
  - It saturates at 16'hFFFF and resets to 0 on rst_n.
  - Extra input cnt_clr (1 bit) clears it synchronously. cnt_clr has priority over increment.
- Undefined:
  - Ports multi_cnt and cnt_clr are absent.
  - No counter logic.
  - All other behaviour is identical.

Decomposition:
- Package enc_pkg:
  - Mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function clog2-safe width helper.
  - Popcount-greater-than-one function.
- Sub-module rr_pick (combinational):
  - Inputs: req[N], start[W].
  - Outputs: hit, idx[W].
  - Finds the first set bit scanning from start with wrap.
  - Top level instantiates it with start = (mode ? ptr : 0), so both modes share one picker.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_idx=0 immediately (async). With en=1 and req=0 after release -> out_valid stays 0.
- Fixed priority (N=8, mode=0, out_ready=1): req=8'b0010_1000 -> next cycle out_idx=3, out_multi=1. req=8'b1000_0000 -> out_idx=7, out_multi=0.
- Round-robin (N=8, mode=1, ptr=0, out_ready=1): req=8'b1000_1001 held for 4 cycles -> out_idx sequence 0, 3, 7, 0. The ptr after the grant of 7 wraps to 0.
- Backpressure: out_ready=0 with out_valid=1 and out_idx=2; change req to 8'h10 -> out_idx stays 2 for 5 cycles, ptr is unchanged. Raising out_ready -> the same cycle pops, capture gives out_idx=4 next cycle with out_valid held at 1.
- Enable gating: en=0 with req=8'hFF -> no capture. A pending result pops and out_valid drops to 0.
- ENC_MULTI_CNT_EN: 3 multi-hot captures plus 1 single-hot capture -> multi_cnt=3. cnt_clr pulsed together with a multi-hot capture -> multi_cnt=0. Preload near saturation -> value holds at 16'hFFFF.
